// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the execute-stage ALU.
package alu_pkg;
   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_NOT  = 4'd1;
   localparam logic [3:0] OP_INC  = 4'd2;
   localparam logic [3:0] OP_DEC  = 4'd3;
   localparam logic [3:0] OP_MOV  = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_SETC = 4'd11;
   localparam logic [3:0] OP_CLRC = 4'd12;
   localparam logic [3:0] OP_PASS = 4'd13;
   localparam logic [3:0] OP_LDI  = 4'd14;
   localparam logic [3:0] OP_MUL  = 4'd15;

   localparam int FLG_C = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 0;

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;
endpackage

// File: rtl/alu_exec_stage_if.sv
// Operand/handshake/result bundle between the issue logic and the execute-stage ALU.
interface alu_exec_stage_if #(
   parameter int N       = 16,
   parameter int FWD_N   = 2,
   parameter int SHAMT_W = 4,
   parameter int RID_W   = 3
);
   logic                     in_valid;
   logic                     in_ready;
   logic [3:0]               op;
   logic [N-1:0]             src_a;
   logic [N-1:0]             src_b;
   logic [RID_W-1:0]         rs_a;
   logic [RID_W-1:0]         rs_b;
   logic [N-1:0]             imm;
   logic [SHAMT_W:0]         shamt;
   logic [FWD_N-1:0]         fwd_valid;
   logic [FWD_N*RID_W-1:0]   fwd_rd;
   logic [FWD_N*N-1:0]       fwd_data;
   logic                     in_port_sel;
   logic [N-1:0]             in_port;
   logic                     flush;
   logic                     flag_save;
   logic                     flag_restore;
   logic                     out_valid;
   logic [N-1:0]             result;
   logic [2:0]               flags;
   logic                     busy;

   modport master (
      output in_valid, op, src_a, src_b, rs_a, rs_b, imm, shamt,
             fwd_valid, fwd_rd, fwd_data, in_port_sel, in_port,
             flush, flag_save, flag_restore,
      input  in_ready, out_valid, result, flags, busy
   );

   modport slave (
      input  in_valid, op, src_a, src_b, rs_a, rs_b, imm, shamt,
             fwd_valid, fwd_rd, fwd_data, in_port_sel, in_port,
             flush, flag_save, flag_restore,
      output in_ready, out_valid, result, flags, busy
   );
endinterface

// File: rtl/alu_fwd_mux.sv
// Priority operand bypass: the youngest matching write-back slot (lowest index) wins over the register file.
module alu_fwd_mux #(
   parameter int N     = 16,
   parameter int FWD_N = 2,
   parameter int RID_W = 3
) (
   input  logic [RID_W-1:0]       rs_i,
   input  logic [N-1:0]           reg_i,
   input  logic [FWD_N-1:0]       fwd_valid_i,
   input  logic [FWD_N*RID_W-1:0] fwd_rd_i,
   input  logic [FWD_N*N-1:0]     fwd_data_i,
   output logic [N-1:0]           opnd_o
);
   // Walk oldest to youngest so the youngest match is written last.
   always_comb begin
      opnd_o = reg_i;
      for (int j = FWD_N - 1; j >= 0; j--) begin
         if (fwd_valid_i[j] && (fwd_rd_i[j*RID_W +: RID_W] == rs_i))
            opnd_o = fwd_data_i[j*N +: N];
      end
   end
endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU: operand bypass, C/Z/N flags with shadow copy, iterative shift-add multiply.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int N       = 16,
   parameter int FWD_N   = 2,
   parameter int SHAMT_W = 4,
   parameter int RID_W   = 3
) (
   input logic             clk,
   input logic             rst_n,
   alu_exec_stage_if.slave bus
);
   localparam int CNT_W = $clog2(N + 1);

   logic [N-1:0]     opa, opb;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_step;
   logic [N-1:0]     mplr_q, mplr_d;
   logic [N-1:0]     res_q, res_d, alu_res;
   logic [2:0]       flg_q, flg_d, shd_q, shd_d, alu_flg, upd_flg;
   logic             ov_q, ov_d, alu_c, upd_zn;

   alu_fwd_mux #(.N(N), .FWD_N(FWD_N), .RID_W(RID_W)) u_fwd_a (
      .rs_i(bus.rs_a), .reg_i(bus.src_a), .fwd_valid_i(bus.fwd_valid),
      .fwd_rd_i(bus.fwd_rd), .fwd_data_i(bus.fwd_data), .opnd_o(opa)
   );

   alu_fwd_mux #(.N(N), .FWD_N(FWD_N), .RID_W(RID_W)) u_fwd_b (
      .rs_i(bus.rs_b), .reg_i(bus.src_b), .fwd_valid_i(bus.fwd_valid),
      .fwd_rd_i(bus.fwd_rd), .fwd_data_i(bus.fwd_data), .opnd_o(opb)
   );

   // Single-cycle datapath; carry defaults to held so ops that leave C alone need no branch.
   always_comb begin
      alu_res = res_q;
      alu_c   = flg_q[FLG_C];
      upd_zn  = 1'b0;
      alu_flg = flg_q;
      case (bus.op)
         OP_NOP:  if (bus.in_port_sel) alu_res = bus.in_port;
         OP_NOT:  begin alu_res = ~opa; alu_c = 1'b0; upd_zn = 1'b1; end
         OP_INC:  begin {alu_c, alu_res} = {1'b0, opa} + (N+1)'(1); upd_zn = 1'b1; end
         OP_DEC:  begin {alu_c, alu_res} = {1'b0, opa} - (N+1)'(1); upd_zn = 1'b1; end
         OP_MOV:  alu_res = opa;
         OP_ADD:  begin {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb}; upd_zn = 1'b1; end
         OP_SUB:  begin {alu_c, alu_res} = {1'b0, opa} - {1'b0, opb}; upd_zn = 1'b1; end
         OP_AND:  begin alu_res = opa & opb; upd_zn = 1'b1; end
         OP_OR:   begin alu_res = opa | opb; upd_zn = 1'b1; end
         OP_SHL: begin
            upd_zn = 1'b1;
            if (bus.shamt == '0)                        alu_res = opa;
            else if (bus.shamt > (SHAMT_W+1)'(N))       begin alu_res = '0; alu_c = 1'b0; end
            else                                        {alu_c, alu_res} = {1'b0, opa} << bus.shamt;
         end
         OP_SHR: begin
            upd_zn = 1'b1;
            if (bus.shamt == '0)                        alu_res = opa;
            else if (bus.shamt > (SHAMT_W+1)'(N))       begin alu_res = '0; alu_c = 1'b0; end
            else                                        {alu_res, alu_c} = {opa, 1'b0} >> bus.shamt;
         end
         OP_SETC: alu_c = 1'b1;
         OP_CLRC: alu_c = 1'b0;
         OP_PASS: alu_res = opa;
         OP_LDI:  alu_res = bus.imm;
         default: ;
      endcase
      alu_flg[FLG_C] = alu_c;
      alu_flg[FLG_Z] = upd_zn ? (alu_res == '0) : flg_q[FLG_Z];
      alu_flg[FLG_N] = upd_zn ? alu_res[N-1]    : flg_q[FLG_N];
   end

   assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      res_d   = res_q;
      upd_flg = flg_q;
      ov_d    = 1'b0;
      if (bus.flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.in_valid) begin
               if (bus.op == OP_MUL) begin
                  state_d = ST_MUL;
                  cnt_d   = CNT_W'(N);
                  acc_d   = '0;
                  mcand_d = {{N{1'b0}}, opa};
                  mplr_d  = opb;
               end else begin
                  ov_d    = 1'b1;
                  res_d   = alu_res;
                  upd_flg = alu_flg;
               end
            end
            ST_MUL: begin
               acc_d   = acc_step;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d        = ST_IDLE;
                  ov_d           = 1'b1;
                  res_d          = acc_step[N-1:0];
                  upd_flg[FLG_C] = |acc_step[2*N-1:N];
                  upd_flg[FLG_Z] = (acc_step[N-1:0] == '0);
                  upd_flg[FLG_N] = acc_step[N-1];
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // Restore overrides any same-cycle update; save sees pre-update flags, so both together swap.
      flg_d = bus.flag_restore ? shd_q : upd_flg;
      shd_d = bus.flag_save ? flg_q : shd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         res_q   <= '0;
         flg_q   <= '0;
         shd_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
         shd_q   <= shd_d;
         ov_q    <= ov_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.busy      = (state_q == ST_MUL);
   assign bus.out_valid = ov_q;
   assign bus.result    = res_q;
   assign bus.flags     = flg_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Vector table plus hand sequences for the execute-stage ALU; results checked through an expected-value queue.
module tb_alu_exec_stage;
   import alu_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;    // also drives imm and in_port
      logic [4:0]  sh;
      logic        sel;
      logic [15:0] res;
      logic [2:0]  flg;  // {C,Z,N}
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  flg;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;
   vec_t vecs[$];
   exp_t exp_q[$];

   alu_exec_stage_if #(.N(16), .FWD_N(2), .SHAMT_W(4), .RID_W(3)) bus ();

   alu_exec_stage #(.N(16), .FWD_N(2), .SHAMT_W(4), .RID_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic vec_t mkv(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic [4:0] sh,
                                logic sel, logic [15:0] res, logic [2:0] flg);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.sh = sh; v.sel = sel; v.res = res; v.flg = flg;
      return v;
   endfunction

   task automatic apply(vec_t v);
      bus.op = v.op; bus.src_a = v.a; bus.src_b = v.b; bus.imm = v.b;
      bus.in_port = v.b; bus.in_port_sel = v.sel; bus.shamt = v.sh;
      bus.in_valid = 1'b1;
   endtask

   task automatic push_exp(vec_t v);
      exp_t e;
      e.res = v.res; e.flg = v.flg;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!bus.in_ready && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      if (!bus.in_ready) begin
         n_checks++; n_err++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
   endtask

   task automatic drive(vec_t v);
      apply(v);
      wait_ready();
      push_exp(v);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_out_valid: got result %h flags %b expected no pulse",
                     bus.result, bus.flags);
         end else begin
            e = exp_q.pop_front();
            check("sb_result", 32'(bus.result), 32'(e.res));
            check("sb_flags", 32'(bus.flags), 32'(e.flg));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lo;
      bus.in_valid = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.rs_a = 3'd0; bus.rs_b = 3'd1;
      bus.imm = 0; bus.shamt = 0; bus.fwd_valid = 0; bus.fwd_rd = 0; bus.fwd_data = 0;
      bus.in_port_sel = 0; bus.in_port = 0; bus.flush = 0; bus.flag_save = 0; bus.flag_restore = 0;

      //           op       a        b        sh    sel   result   {C,Z,N}
      vecs.push_back(mkv(OP_ADD,  16'hFFFF, 16'h0001, 5'd0,  1'b0, 16'h0000, 3'b110));
      vecs.push_back(mkv(OP_SUB,  16'h0003, 16'h0005, 5'd0,  1'b0, 16'hFFFE, 3'b101));
      vecs.push_back(mkv(OP_AND,  16'hF0F0, 16'h0FF0, 5'd0,  1'b0, 16'h00F0, 3'b100));
      vecs.push_back(mkv(OP_OR,   16'h8000, 16'h0001, 5'd0,  1'b0, 16'h8001, 3'b101));
      vecs.push_back(mkv(OP_NOT,  16'h00FF, 16'h0000, 5'd0,  1'b0, 16'hFF00, 3'b001));
      vecs.push_back(mkv(OP_INC,  16'h7FFF, 16'h0000, 5'd0,  1'b0, 16'h8000, 3'b001));
      vecs.push_back(mkv(OP_DEC,  16'h0000, 16'h0000, 5'd0,  1'b0, 16'hFFFF, 3'b101));
      vecs.push_back(mkv(OP_SHL,  16'h8001, 16'h0000, 5'd1,  1'b0, 16'h0002, 3'b100));
      vecs.push_back(mkv(OP_SHL,  16'h8001, 16'h0000, 5'd0,  1'b0, 16'h8001, 3'b101));
      vecs.push_back(mkv(OP_SHL,  16'h8001, 16'h0000, 5'd17, 1'b0, 16'h0000, 3'b010));
      vecs.push_back(mkv(OP_SETC, 16'h1111, 16'h0000, 5'd0,  1'b0, 16'h0000, 3'b110));
      vecs.push_back(mkv(OP_SHR,  16'h0003, 16'h0000, 5'd1,  1'b0, 16'h0001, 3'b100));
      vecs.push_back(mkv(OP_SHR,  16'h8000, 16'h0000, 5'd16, 1'b0, 16'h0000, 3'b110));
      vecs.push_back(mkv(OP_SHL,  16'h0001, 16'h0000, 5'd16, 1'b0, 16'h0000, 3'b110));
      vecs.push_back(mkv(OP_CLRC, 16'h2222, 16'h0000, 5'd0,  1'b0, 16'h0000, 3'b010));
      vecs.push_back(mkv(OP_MOV,  16'h1234, 16'h0000, 5'd0,  1'b0, 16'h1234, 3'b010));
      vecs.push_back(mkv(OP_LDI,  16'h1111, 16'hBEEF, 5'd0,  1'b0, 16'hBEEF, 3'b010));
      vecs.push_back(mkv(OP_PASS, 16'h4321, 16'h0000, 5'd0,  1'b0, 16'h4321, 3'b010));
      vecs.push_back(mkv(OP_NOP,  16'h0000, 16'h5A5A, 5'd0,  1'b1, 16'h5A5A, 3'b010));
      vecs.push_back(mkv(OP_NOP,  16'h0000, 16'h0000, 5'd0,  1'b0, 16'h5A5A, 3'b010));
      vecs.push_back(mkv(OP_SUB,  16'h0005, 16'h0005, 5'd0,  1'b0, 16'h0000, 3'b010));
      vecs.push_back(mkv(OP_ADD,  16'h7FFF, 16'h0001, 5'd0,  1'b0, 16'h8000, 3'b001));
      vecs.push_back(mkv(OP_DEC,  16'h0001, 16'h0000, 5'd0,  1'b0, 16'h0000, 3'b010));
      vecs.push_back(mkv(OP_MUL,  16'h00FF, 16'h0003, 5'd0,  1'b0, 16'h02FD, 3'b000));
      vecs.push_back(mkv(OP_MUL,  16'h1234, 16'h0010, 5'd0,  1'b0, 16'h2340, 3'b100));
      vecs.push_back(mkv(OP_AND,  16'hFFFF, 16'h0000, 5'd0,  1'b0, 16'h0000, 3'b110));
      vecs.push_back(mkv(OP_MUL,  16'hFFFF, 16'hFFFF, 5'd0,  1'b0, 16'h0001, 3'b100));
      vecs.push_back(mkv(OP_SHR,  16'h0001, 16'h0000, 5'd31, 1'b0, 16'h0000, 3'b010));

      #12;
      check("rst_result", 32'(bus.result), 32'h0);
      check("rst_flags", 32'(bus.flags), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) drive(vecs[i]);

      // Forwarding priority: slot 0 beats slot 1, register file loses to both.
      bus.rs_a = 3'd2;
      bus.fwd_rd = {3'd2, 3'd2};
      bus.fwd_data = {16'h0020, 16'h0010};
      bus.fwd_valid = 2'b11;
      drive(mkv(OP_INC, 16'h0999, 16'h0000, 5'd0, 1'b0, 16'h0011, 3'b000));
      bus.fwd_valid = 2'b10;
      drive(mkv(OP_INC, 16'h0999, 16'h0000, 5'd0, 1'b0, 16'h0021, 3'b000));
      bus.rs_b = 3'd5;
      bus.fwd_rd = {3'd5, 3'd2};
      bus.fwd_data = {16'h0100, 16'h0010};
      bus.fwd_valid = 2'b11;
      drive(mkv(OP_ADD, 16'h9999, 16'h0001, 5'd0, 1'b0, 16'h0110, 3'b000));
      bus.fwd_valid = 2'b00; bus.rs_a = 3'd0; bus.rs_b = 3'd1;

      // Multiply latency; the queued ADD must be taken on the out_valid cycle.
      drive(mkv(OP_MUL, 16'h0100, 16'h0100, 5'd0, 1'b0, 16'h0000, 3'b110));
      apply(mkv(OP_ADD, 16'h0001, 16'h0001, 5'd0, 1'b0, 16'h0002, 3'b000));
      push_exp(mkv(OP_ADD, 16'h0001, 16'h0001, 5'd0, 1'b0, 16'h0002, 3'b000));
      lo = 0;
      @(negedge clk);
      check("mul_busy", 32'(bus.busy), 32'h1);
      while (!bus.in_ready && lo < 40) begin
         lo++;
         @(negedge clk);
      end
      check("mul_ready_low_cycles", 32'(lo), 32'd16);
      check("mul_out_valid_with_ready", 32'(bus.out_valid), 32'h1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      // Flush in the fifth multiply cycle: no result, no flag change.
      apply(mkv(OP_MUL, 16'h0003, 16'h0005, 5'd0, 1'b0, 16'h0000, 3'b000));
      wait_ready();
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush_in_ready", 32'(bus.in_ready), 32'h1);
      check("flush_busy", 32'(bus.busy), 32'h0);
      repeat (20) @(posedge clk);
      #1;
      check("flush_result_held", 32'(bus.result), 32'h0002);
      check("flush_flags_held", 32'(bus.flags), 32'h0);

      // Flush also kills an op presented in the same cycle.
      apply(mkv(OP_ADD, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 16'h0000, 3'b110));
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_idle_no_pulse", 32'(bus.out_valid), 32'h0);
      check("flush_idle_result", 32'(bus.result), 32'h0002);
      check("flush_idle_flags", 32'(bus.flags), 32'h0);
      @(posedge clk); #1;

      // Shadow flags: save samples pre-update flags, restore wins over a same-cycle update.
      drive(mkv(OP_SUB, 16'h0000, 16'h0001, 5'd0, 1'b0, 16'hFFFF, 3'b101));
      bus.flag_save = 1'b1;
      drive(mkv(OP_ADD, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 16'h0000, 3'b110));
      bus.flag_save = 1'b0;
      bus.flag_restore = 1'b1;
      drive(mkv(OP_ADD, 16'h0001, 16'h0001, 5'd0, 1'b0, 16'h0002, 3'b101));
      bus.flag_restore = 1'b0;
      drive(mkv(OP_MOV, 16'h00AA, 16'h0000, 5'd0, 1'b0, 16'h00AA, 3'b101));
      drive(mkv(OP_ADD, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 16'h0000, 3'b110));
      bus.flag_save = 1'b1; bus.flag_restore = 1'b1;
      @(posedge clk); #1;
      bus.flag_save = 1'b0; bus.flag_restore = 1'b0;
      check("swap_flags", 32'(bus.flags), 32'b101);
      bus.flag_restore = 1'b1;
      @(posedge clk); #1;
      bus.flag_restore = 1'b0;
      check("swap_shadow_restore", 32'(bus.flags), 32'b110);
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      // Asynchronous reset in the middle of a multiply.
      apply(mkv(OP_MUL, 16'h0100, 16'h0002, 5'd0, 1'b0, 16'h0200, 3'b000));
      wait_ready();
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 32'h0);
      check("arst_in_ready", 32'(bus.in_ready), 32'h1);
      check("arst_out_valid", 32'(bus.out_valid), 32'h0);
      check("arst_result", 32'(bus.result), 32'h0);
      check("arst_flags", 32'(bus.flags), 32'h0);
      #3 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("arst_no_late_result", 32'(bus.result), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
